// File: rtl/sccb_slave.sv
// sccb_slave: SCCB write-only slave receiver.
// Oversamples SIO_C/SIO_D on i_Clk, assembles ID / sub-address / data
// from a 27-sample frame and reports a register write on the stop condition.
// Optional feature: define SCCB_SLAVE_DATA_INV_EN to invert every sampled
// bit before it is shifted in (for masters that drive complemented data).
module sccb_slave #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         TIMEOUT_CYC = 4000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_SIO_C,
  input  logic       i_SIO_D,
  output logic       o_WrEn,
  output logic [7:0] o_WrAddr,
  output logic [7:0] o_WrData,
  output logic       o_IdErr,
  output logic       o_Busy
);

  typedef enum logic [1:0] {IDLE, RECV, WAIT_STOP, DRAIN} state_t;

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYC);

  // bit 1 = SIO_C, bit 0 = SIO_D
  logic [1:0]  sync_meta_reg;
  logic [1:0]  sync_reg;
  logic [1:0]  sync_prev_reg;

  state_t      state_reg, state_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [15:0] idle_cnt_reg, idle_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  id_reg, id_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        wr_en_reg, wr_en_next;
  logic        id_err_reg, id_err_next;
  logic [7:0]  wr_addr_reg, wr_addr_next;
  logic [7:0]  wr_data_reg, wr_data_next;

  logic        sioc_fall;
  logic        sioc_edge;
  logic        stop_det;
  logic        timeout;
  logic        sample_bit;
  logic [4:0]  bit_cnt_inc;
  logic [7:0]  shift_in;

  // Two-flop synchronisers plus one history flop for edge detection
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      sync_meta_reg <= 2'b00;
      sync_reg      <= 2'b00;
      sync_prev_reg <= 2'b00;
    end else begin
      sync_meta_reg <= {i_SIO_C, i_SIO_D};
      sync_reg      <= sync_meta_reg;
      sync_prev_reg <= sync_reg;
    end
  end

  // Stop = SIO_D rising while SIO_C is high; data is sampled on SIO_C falling
  assign sioc_fall   = sync_prev_reg[1] & ~sync_reg[1];
  assign sioc_edge   = sync_prev_reg[1] ^ sync_reg[1];
  assign stop_det    = sync_reg[1] & ~sync_prev_reg[0] & sync_reg[0];
  assign timeout     = (idle_cnt_reg >= TIMEOUT_VAL);
  assign bit_cnt_inc = bit_cnt_reg + 5'd1;
  assign shift_in    = {shift_reg[6:0], sample_bit};

`ifdef SCCB_SLAVE_DATA_INV_EN
  assign sample_bit = ~sync_reg[0];
`else
  assign sample_bit = sync_reg[0];
`endif

  // Frame state machine: next state, byte capture and output pulses
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    id_next       = id_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    wr_en_next    = 1'b0;
    id_err_next   = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    idle_cnt_next = idle_cnt_reg;

    if (sioc_edge) begin
      idle_cnt_next = 16'd0;
    end else if (idle_cnt_reg != 16'hFFFF) begin
      idle_cnt_next = idle_cnt_reg + 16'd1;
    end

    case (state_reg)
      IDLE: begin
        if (sioc_fall) begin
          shift_next   = shift_in;
          bit_cnt_next = 5'd1;
          state_next   = RECV;
        end
      end
      RECV: begin
        if (timeout) begin
          bit_cnt_next = 5'd0;
          state_next   = IDLE;
        end else if (sioc_fall) begin
          // The byte is the 8 samples before the don't-care sample
          shift_next   = shift_in;
          bit_cnt_next = bit_cnt_inc;
          case (bit_cnt_inc)
            5'd9:    id_next   = shift_reg;
            5'd18:   addr_next = shift_reg;
            5'd27: begin
              data_next  = shift_reg;
              state_next = WAIT_STOP;
            end
            default: ;
          endcase
        end
      end
      WAIT_STOP: begin
        if (timeout) begin
          bit_cnt_next = 5'd0;
          state_next   = IDLE;
        end else if (sioc_fall) begin
          state_next = DRAIN;
        end else if (stop_det) begin
          bit_cnt_next = 5'd0;
          state_next   = IDLE;
          if (id_reg == DEV_ID) begin
            wr_en_next   = 1'b1;
            wr_addr_next = addr_reg;
            wr_data_next = data_reg;
          end else begin
            id_err_next = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (timeout || stop_det) begin
          bit_cnt_next = 5'd0;
          state_next   = IDLE;
        end
      end
      default: begin
        bit_cnt_next = 5'd0;
        state_next   = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 5'd0;
      idle_cnt_reg <= 16'd0;
      shift_reg    <= 8'h00;
      id_reg       <= 8'h00;
      addr_reg     <= 8'h00;
      data_reg     <= 8'h00;
      wr_en_reg    <= 1'b0;
      id_err_reg   <= 1'b0;
      wr_addr_reg  <= 8'h00;
      wr_data_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      shift_reg    <= shift_next;
      id_reg       <= id_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      wr_en_reg    <= wr_en_next;
      id_err_reg   <= id_err_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  assign o_WrEn   = wr_en_reg;
  assign o_IdErr  = id_err_reg;
  assign o_WrAddr = wr_addr_reg;
  assign o_WrData = wr_data_reg;
  assign o_Busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave: table-driven frames with a pulse scoreboard, plus
// hand-written timeout, framing-error and mid-frame reset sequences.
module tb_sccb_slave;

`ifdef SCCB_SLAVE_DATA_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  localparam int Q = 5;  // quarter SIO_C period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sio_c = 1'b1;
  logic       sio_d = 1'b1;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       id_err;
  logic       busy;

  sccb_slave dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_SIO_C (sio_c),
    .i_SIO_D (sio_d),
    .o_WrEn  (wr_en),
    .o_WrAddr(wr_addr),
    .o_WrData(wr_data),
    .o_IdErr (id_err),
    .o_Busy  (busy)
  );

  always #10 clk = ~clk;

  // kind: 1 = write, 2 = ID error, 3 = both at once, 4 = back-to-back pulse
  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] id;
    logic [7:0] addr;
    logic [7:0] data;
    bit         exp_wr;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_data = 8'h00;
  bit   prev_pulse = 1'b0;

  // Record every output pulse as it happens
  always @(negedge clk) begin
    ev_t o;
    if (wr_en || id_err) begin
      o.kind = (wr_en && id_err) ? 3 : (wr_en ? 1 : 2);
      o.addr = wr_addr;
      o.data = wr_data;
      obs_q.push_back(o);
      if (prev_pulse) begin
        o.kind = 4;
        obs_q.push_back(o);
      end
    end
    prev_pulse = wr_en | id_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] build(input logic [7:0] id, input logic [7:0] a,
                                        input logic [7:0] d);
    logic [2:0] dc;
    dc = 3'($urandom_range(0, 7));
    return {id, dc[2], a, dc[1], d, dc[0]};
  endfunction

  // Sends v[n-1] .. v[0]; each bit is sampled by the slave on SIO_C falling
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sio_d = v[i] ^ INV;
      wait_clk(Q);
      sio_c = 1'b0;
      wait_clk(2 * Q);
      sio_c = 1'b1;
      wait_clk(Q);
    end
  endtask

  // SIO_D low then high while SIO_C stays high
  task automatic send_stop();
    sio_d = 1'b0;
    wait_clk(Q);
    sio_d = 1'b1;
    wait_clk(2 * Q);
  endtask

  // Pops every expected pulse against observed ones, then checks for extras
  task automatic check_pulses(input string tag);
    ev_t e, o;
    int  n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (obs_q.size() == 0 && n < 200) begin
        @(posedge clk);
        n++;
      end
      if (obs_q.size() == 0) begin
        chk({tag, "_pulse_missing"}, 0, e.kind);
      end else begin
        o = obs_q.pop_front();
        chk({tag, "_kind"}, o.kind, e.kind);
        chk({tag, "_addr"}, o.addr, e.addr);
        chk({tag, "_data"}, o.data, e.data);
      end
    end
    wait_clk(20);
    chk({tag, "_extra_pulses"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic run_frame(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d,
                           input string tag);
    ev_t e;
    if (id == 8'h42) begin
      m_addr = a;
      m_data = d;
      e.kind = 1;
    end else begin
      e.kind = 2;
    end
    e.addr = m_addr;
    e.data = m_data;
    exp_q.push_back(e);
    $display("frame %s: id=%02h addr=%02h data=%02h expect kind %0d", tag, id, a, d, e.kind);
    send_bits(32'(build(id, a, d)), 27);
    send_stop();
    check_pulses(tag);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    vec_t       vecs[7];
    logic [26:0] f;
    int         n;

    vecs[0] = '{8'h42, 8'h11, 8'h22, 1'b1};
    vecs[1] = '{8'h43, 8'h12, 8'h34, 1'b0};
    vecs[2] = '{8'h42, 8'h0C, 8'h80, 1'b1};
    vecs[3] = '{8'h42, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{8'h42, 8'hFF, 8'hFF, 1'b1};
    vecs[5] = '{8'hBD, 8'hA5, 8'h5A, 1'b0};
    vecs[6] = '{8'h42, 8'h3C, 8'hC3, 1'b1};

    // Reset state
    wait_clk(4);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_id_err", id_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    @(posedge clk);
    rst = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].id, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end

    // Partial frame of 10 samples, then bus idle until timeout
    f = build(8'h42, 8'h99, 8'h77);
    $display("frame timeout: 10 samples then idle");
    send_bits(32'(f >> 17), 10);
    chk("to_busy_mid", busy, 1);
    wait_clk(3850);
    chk("to_busy_before_limit", busy, 1);
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("to_busy_dropped", busy, 0);
    sio_d = 1'b1;
    check_pulses("to");
    run_frame(8'h42, 8'h3A, 8'h04, "after_to");

    // 28 falling edges: framing error, drained on stop
    f = build(8'h42, 8'h66, 8'h99);
    $display("frame overrun: 28 samples then stop");
    send_bits({4'h0, f, f[0]}, 28);
    chk("ov_busy_before_stop", busy, 1);
    send_stop();
    chk("ov_busy_after_stop", busy, 0);
    check_pulses("ov");
    run_frame(8'h42, 8'h55, 8'hAA, "after_ov");

    // Reset after 15 samples
    f = build(8'h42, 8'h77, 8'h88);
    $display("frame reset: 15 samples then reset");
    send_bits(32'(f >> 12), 15);
    chk("mr_busy_mid", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_wr_en", wr_en, 0);
    chk("mr_id_err", id_err, 0);
    chk("mr_busy", busy, 0);
    chk("mr_wr_addr", wr_addr, 8'h00);
    chk("mr_wr_data", wr_data, 8'h00);
    m_addr = 8'h00;
    m_data = 8'h00;
    wait_clk(5);
    rst = 1'b1;
    sio_d = 1'b1;
    wait_clk(10);
    check_pulses("mr");
    run_frame(8'h42, 8'h01, 8'hFF, "after_mr");
    run_frame(8'h99, 8'h12, 8'h34, "after_mr_iderr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_slave.md
SCCB_SLAVE -- requirements
Module: sccb_slave

Interface
REQ-001 Parameter DEV_ID, default 8'h42: device ID byte the block responds to.
REQ-002 Parameter TIMEOUT_CYC, default 4000: i_Clk cycles without an i_SIO_C edge before a partial frame is discarded.
REQ-003 i_Clk  input  1  system clock (50 MHz nominal).
REQ-004 i_Rst  input  1  asynchronous active-low reset.
REQ-005 i_SIO_C  input  1  SCCB clock from the team's SCCB master, asynchronous to i_Clk.
REQ-006 i_SIO_D  input  1  SCCB data from the master, asynchronous to i_Clk.
REQ-007 o_WrEn  output  1  one-cycle pulse: valid register write decoded.
REQ-008 o_WrAddr  output  8  register sub-address, held until the next o_WrEn.
REQ-009 o_WrData  output  8  register data, held until the next o_WrEn.
REQ-010 o_IdErr  output  1  one-cycle pulse: a complete frame carried an ID other than DEV_ID.
REQ-011 o_Busy  output  1  high while a frame is partially received.

Function
REQ-012 Synchronise i_SIO_C and i_SIO_D with two flops each on i_Clk; detect edges on the synchronised signals only, giving 2-3 cycles of input latency.
REQ-013 Sample synchronised SIO_D on each SIO_C falling edge; a frame is 27 samples: 3 phases of 9 bits, 8 data bits MSB first plus 1 don't-care bit.
REQ-014 Shift samples into an 8-bit register; on samples 9, 18 and 27, latch the byte as ID, sub-address or data respectively.
REQ-015 Use states IDLE, RECV, WAIT_STOP and DRAIN.
REQ-016 IDLE -> RECV on the first SIO_C falling edge, which counts as sample 1.
REQ-017 RECV -> WAIT_STOP after sample 27.
REQ-018 In WAIT_STOP, an SIO_D rising edge while SIO_C is high is the stop condition; stop -> IDLE.
REQ-019 SIO_D edges while SIO_C is high are ignored in IDLE and RECV, since the master changes data during SIO_C high.
REQ-020 On stop with ID == DEV_ID: pulse o_WrEn the cycle after stop detection, with o_WrAddr/o_WrData updated in that same cycle.
REQ-021 On stop with ID != DEV_ID: pulse o_IdErr instead and leave o_WrAddr/o_WrData unchanged.
REQ-022 An SIO_C falling edge in WAIT_STOP (28th sample) is a framing error: discard the frame and go to DRAIN; DRAIN -> IDLE on the next stop condition, with no pulses.
REQ-023 A 16-bit idle counter clears on every SIO_C edge; in RECV, WAIT_STOP or DRAIN, reaching TIMEOUT_CYC discards the frame and returns to IDLE with no pulses.
REQ-024 o_Busy = 1 in RECV, WAIT_STOP and DRAIN; o_Busy = 0 in IDLE.
REQ-025 o_WrEn and o_IdErr are never high in the same cycle and never high on consecutive cycles.

Reset
REQ-026 While i_Rst is low: state = IDLE, sync flops = 0, bit counter = 0, idle counter = 0, shift register = 0, o_WrEn = 0, o_IdErr = 0, o_Busy = 0, o_WrAddr = 8'h00, o_WrData = 8'h00.
REQ-027 Reset asserted mid-frame discards the frame; after release, reception starts at the next SIO_C falling edge as sample 1.

Configuration
REQ-028 Macro SCCB_SLAVE_DATA_INV_EN defined: each sampled bit is inverted before shifting, matching the team's SCCB master, which drives the complement of each data bit.
REQ-029 Macro SCCB_SLAVE_DATA_INV_EN undefined: sampled bits shift in unmodified (standard SCCB polarity); all other behaviour is identical.

Verification
REQ-030 Macro defined; team SCCB master sends addr 8'h11, data 8'h22 -> exactly one o_WrEn pulse with o_WrAddr=8'h11, o_WrData=8'h22; o_Busy low afterwards.
REQ-031 Macro defined; bit-banged frame with ID 8'h43, addr 8'h12, data 8'h34 -> one o_IdErr pulse, no o_WrEn, o_WrAddr/o_WrData keep previous values.
REQ-032 Frame stops after 10 SIO_C falling edges and the bus idles for 4000 cycles -> o_Busy falls, no pulses; next full frame 8'h42/8'h3A/8'h04 -> o_WrEn with 8'h3A/8'h04.
REQ-033 28 falling edges then stop -> no pulses, o_Busy high until stop then low; following valid frame 8'h42/8'h55/8'hAA -> written correctly.
REQ-034 i_Rst pulled low after 15 samples of a frame -> all outputs at reset values; after release, frame 8'h42/8'h01/8'hFF -> o_WrEn with 8'h01/8'hFF.
REQ-035 Macro undefined; non-inverted frame 8'h42/8'h0C/8'h80 -> o_WrEn with 8'h0C/8'h80.
